fir_coef_loader: RTL and testbench

Byte-stream coefficient loader that sits directly upstream of the 16-tap FIR filter and drives its sixteen 12-bit coefficient inputs. It parses framed coefficient sets from a byte source (UART receiver or host bridge), checks each frame, and commits all sixteen coefficients atomically. A corrupt or partial frame never changes the coefficients the filter sees. `coef_valid` tells the top level that a committed set exists, so the top can gate the filter enable with it.

---
 rtl/fir_coef_loader.sv | 207 ++++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//
// Byte-stream coefficient loader for the 16-tap FIR filter. Parses framed
// coefficient sets from a byte source, verifies each frame, and commits all
// sixteen 12-bit coefficients on a single clock edge. A corrupt, malformed
// or stalled frame never disturbs the coefficients the filter is using.
//
// Frame (34 bytes):
//   byte 0      : SYNC
//   bytes 1..32 : coefficient k as low byte, then high byte (k = 0..15)
//                 high[7:4] must be zero, coefficient = {high[3:0], low}
//   byte 33     : XOR of bytes 1..32
//
// Handshake: byte_in is consumed on every rising edge where byte_valid is
// high. There is no backpressure; the loader accepts one byte per cycle,
// back-to-back, in every state.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   byte_in         received byte, qualified by byte_valid
//   byte_valid      single-cycle strobe, may be high on consecutive cycles
//   coef0..coef15   active coefficients (registered), wire to the FIR
//   coef_valid      a frame has committed since reset
//   load_busy       a frame is being received
//   load_done       one-cycle pulse on commit
//   load_err        one-cycle pulse on abort
//   err_code        last abort cause: 0 none, 1 checksum, 2 reserved bits,
//                   3 timeout; holds until the next abort or reset
//   state_dbg       current parser state (0 idle, 1 load, 2 check)

module fir_coef_loader #(
    parameter logic [7:0] SYNC    = 8'hC5,
    parameter int          TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [11:0] coef0,
    output logic [11:0] coef1,
    output logic [11:0] coef2,
    output logic [11:0] coef3,
    output logic [11:0] coef4,
    output logic [11:0] coef5,
    output logic [11:0] coef6,
    output logic [11:0] coef7,
    output logic [11:0] coef8,
    output logic [11:0] coef9,
    output logic [11:0] coef10,
    output logic [11:0] coef11,
    output logic [11:0] coef12,
    output logic [11:0] coef13,
    output logic [11:0] coef14,
    output logic [11:0] coef15,
    output logic        coef_valid,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code,
    output logic [1:0]  state_dbg
);

    // Idle counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_RESERVED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state;
    logic [4:0]       byte_idx;
    logic [7:0]       run_xor;
    logic [CNT_W-1:0] idle_cnt;
    logic [11:0]      shadow [16];
    logic [11:0]      coef_r [16];

    // Byte decode
    logic             is_sync;
    logic             is_high;
    logic             nibble_bad;
    logic             timeout_hit;
    logic [3:0]       slot;
    logic [7:0]       next_xor;

    always_comb begin
        is_sync     = (byte_in == SYNC);
        is_high     = byte_idx[0];
        slot        = byte_idx[4:1];
        nibble_bad  = is_high && (byte_in[7:4] != 4'd0);
        timeout_hit = (idle_cnt == CNT_LAST);
        next_xor    = run_xor ^ byte_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_idx   <= 5'd0;
            run_xor    <= 8'd0;
            idle_cnt   <= '0;
            coef_valid <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= 2'd0;
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 12'd0;
                coef_r[i] <= 12'd0;
            end
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Non-SYNC bytes between frames are dropped silently.
                    if (byte_valid && is_sync) begin
                        state    <= ST_LOAD;
                        byte_idx <= 5'd0;
                        run_xor  <= 8'd0;
                        idle_cnt <= '0;
                    end
                end

                ST_LOAD: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (byte_valid) begin
                        idle_cnt <= '0;
                        if (nibble_bad) begin
                            state    <= ST_IDLE;
                            load_err <= 1'b1;
                            err_code <= ERR_RESERVED;
                        end else begin
                            if (is_high)
                                shadow[slot][11:8] <= byte_in[3:0];
                            else
                                shadow[slot][7:0]  <= byte_in;
                            run_xor  <= next_xor;
                            byte_idx <= byte_idx + 5'd1;
                            if (byte_idx == 5'd31)
                                state <= ST_CHECK;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        load_err <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (byte_valid) begin
                        idle_cnt <= '0;
                        state    <= ST_IDLE;
                        if (byte_in == run_xor) begin
                            // Atomic commit: every coefficient updates on this edge.
                            for (int i = 0; i < 16; i++)
                                coef_r[i] <= shadow[i];
                            coef_valid <= 1'b1;
                            load_done  <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        load_err <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_busy = (state != ST_IDLE);
    assign state_dbg = state;

    assign coef0  = coef_r[0];
    assign coef1  = coef_r[1];
    assign coef2  = coef_r[2];
    assign coef3  = coef_r[3];
    assign coef4  = coef_r[4];
    assign coef5  = coef_r[5];
    assign coef6  = coef_r[6];
    assign coef7  = coef_r[7];
    assign coef8  = coef_r[8];
    assign coef9  = coef_r[9];
    assign coef10 = coef_r[10];
    assign coef11 = coef_r[11];
    assign coef12 = coef_r[12];
    assign coef13 = coef_r[13];
    assign coef14 = coef_r[14];
    assign coef15 = coef_r[15];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader, built with a short timeout (8 cycles)
// so idle-expiry cases stay fast.

module tb_fir_coef_loader;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [11:0] coef_w [16];
    logic        coef_valid;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;
    logic [1:0]  state_dbg;

    int tests_run;
    int tests_failed;

    logic [11:0] tx_coef  [16];
    logic [11:0] exp_coef [16];
    logic [7:0]  frame    [34];

    fir_coef_loader #(.SYNC(8'hC5), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .coef0      (coef_w[0]),
        .coef1      (coef_w[1]),
        .coef2      (coef_w[2]),
        .coef3      (coef_w[3]),
        .coef4      (coef_w[4]),
        .coef5      (coef_w[5]),
        .coef6      (coef_w[6]),
        .coef7      (coef_w[7]),
        .coef8      (coef_w[8]),
        .coef9      (coef_w[9]),
        .coef10     (coef_w[10]),
        .coef11     (coef_w[11]),
        .coef12     (coef_w[12]),
        .coef13     (coef_w[13]),
        .coef14     (coef_w[14]),
        .coef15     (coef_w[15]),
        .coef_valid (coef_valid),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_coefs(input string tag);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s coef%0d", tag, k), 32'(coef_w[k]), 32'(exp_coef[k]));
    endtask

    // ---------------- drivers ----------------
    // Drives one byte for exactly one edge, returns 1 time unit after it.
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Builds a well-formed frame from tx_coef.
    task automatic build_frame();
        logic [7:0] x;
        x = 8'h00;
        frame[0] = 8'hC5;
        for (int k = 0; k < 16; k++) begin
            frame[1 + 2*k] = tx_coef[k][7:0];
            frame[2 + 2*k] = {4'h0, tx_coef[k][11:8]};
        end
        for (int i = 1; i <= 32; i++)
            x = x ^ frame[i];
        frame[33] = x;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            send_byte(frame[i]);
    endtask

    // Sends a full good frame and checks the commit edge plus the next cycle.
    task automatic send_good_frame(input string tag);
        build_frame();
        send_range(0, 32);
        check({tag, " busy before chk"}, 32'(load_busy), 32'd1);
        send_byte(frame[33]);
        for (int k = 0; k < 16; k++)
            exp_coef[k] = tx_coef[k];
        check({tag, " load_done"}, 32'(load_done), 32'd1);
        check({tag, " coef_valid"}, 32'(coef_valid), 32'd1);
        check({tag, " load_busy"}, 32'(load_busy), 32'd0);
        check({tag, " load_err"}, 32'(load_err), 32'd0);
        check_coefs(tag);
        idle_cycles(1);
        check({tag, " done pulse width"}, 32'(load_done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        for (int k = 0; k < 16; k++)
            exp_coef[k] = 12'h000;

        // Reset state
        idle_cycles(3);
        rst = 1'b0;
        check("rst coef_valid", 32'(coef_valid), 32'd0);
        check("rst load_busy", 32'(load_busy), 32'd0);
        check("rst load_done", 32'(load_done), 32'd0);
        check("rst load_err", 32'(load_err), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        check_coefs("rst");

        // 1: coef k = 0x100 + k, back-to-back frame; checksum is 0x00
        for (int k = 0; k < 16; k++)
            tx_coef[k] = 12'h100 + 12'(k);
        build_frame();
        check("t1 checksum byte", 32'(frame[33]), 32'h00);
        send_good_frame("t1");
        check("t1 coef0", 32'(coef_w[0]), 32'h100);
        check("t1 coef15", 32'(coef_w[15]), 32'h10F);

        // 2: same frame, checksum corrupted
        build_frame();
        frame[33] = frame[33] ^ 8'h01;
        send_range(0, 33);
        check("t2 load_err", 32'(load_err), 32'd1);
        check("t2 err_code", 32'(err_code), 32'd1);
        check("t2 load_done", 32'(load_done), 32'd0);
        check("t2 coef_valid", 32'(coef_valid), 32'd1);
        check("t2 load_busy", 32'(load_busy), 32'd0);
        check_coefs("t2");
        idle_cycles(1);
        check("t2 err pulse width", 32'(load_err), 32'd0);
        check("t2 err_code hold", 32'(err_code), 32'd1);

        // 3: coef3 high byte 0x1F -> abort on byte 8
        build_frame();
        frame[8] = 8'h1F;
        send_range(0, 7);
        check("t3 busy before", 32'(load_busy), 32'd1);
        send_byte(frame[8]);
        check("t3 load_err", 32'(load_err), 32'd1);
        check("t3 err_code", 32'(err_code), 32'd2);
        check("t3 load_busy", 32'(load_busy), 32'd0);
        check_coefs("t3");

        // 4a: SYNC + 5 bytes then silence -> load_err exactly TO cycles later
        idle_cycles(2);
        tx_coef[0] = 12'h321; tx_coef[1] = 12'h654; tx_coef[2] = 12'h987;
        build_frame();
        send_range(0, 5);
        for (int i = 1; i <= TO; i++) begin
            idle_cycles(1);
            if (i < TO)
                check($sformatf("t4a no err at %0d", i), 32'(load_err), 32'd0);
            else
                check("t4a err at expiry", 32'(load_err), 32'd1);
        end
        check("t4a err_code", 32'(err_code), 32'd3);
        check("t4a load_busy", 32'(load_busy), 32'd0);
        check_coefs("t4a");

        // 4b: byte on the expiry cycle wins, then the timer restarts
        send_byte(8'hC5);
        idle_cycles(TO - 1);
        check("t4b busy pre-expiry", 32'(load_busy), 32'd1);
        send_byte(8'h11);
        check("t4b byte wins err", 32'(load_err), 32'd0);
        check("t4b byte wins busy", 32'(load_busy), 32'd1);
        idle_cycles(TO - 1);
        check("t4b not yet", 32'(load_err), 32'd0);
        idle_cycles(1);
        check("t4b second expiry", 32'(load_err), 32'd1);

        // 4c: following good frame commits normally
        for (int k = 0; k < 16; k++)
            tx_coef[k] = 12'hA5A ^ 12'(k * 12'h111);
        send_good_frame("t4c");
        check("t4c err_code held", 32'(err_code), 32'd3);

        // 5: junk bytes, then payload with 0xC5 everywhere in the low bytes
        send_byte(8'h00);
        check("t5 junk00 busy", 32'(load_busy), 32'd0);
        send_byte(8'hFF);
        check("t5 junkFF busy", 32'(load_busy), 32'd0);
        for (int k = 0; k < 16; k++)
            tx_coef[k] = {4'(k), 8'hC5};
        send_good_frame("t5");
        check("t5 coef7", 32'(coef_w[7]), 32'h7C5);

        // 6: reset at byte 20 clears everything, then a fresh frame commits
        for (int k = 0; k < 16; k++)
            tx_coef[k] = 12'hFFF - 12'(k);
        build_frame();
        send_range(0, 19);
        rst        = 1'b1;
        byte_in    = frame[20];
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        rst        = 1'b0;
        for (int k = 0; k < 16; k++)
            exp_coef[k] = 12'h000;
        check("t6 coef_valid", 32'(coef_valid), 32'd0);
        check("t6 load_busy", 32'(load_busy), 32'd0);
        check("t6 err_code", 32'(err_code), 32'd0);
        check("t6 load_done", 32'(load_done), 32'd0);
        check_coefs("t6");
        send_good_frame("t6");
        check("t6 coef15", 32'(coef_w[15]), 32'hFF0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
